cc_unit: RTL
============

Name: cc_unit

Overview:
- Condition-code unit for the Y86-64 sequential execute stage.
- Consumes the 64-bit ALU operands, function code and result produced by the ADD/SUB/AND/XOR datapaths.
- Derives ZF/SF/OF from those values and holds them in a clocked CC register.
- Evaluates the jXX/cmovXX condition `cnd` from the currently stored flags.

Parameters:
- n, 64, datapath width of ALU operands and result.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- set_cc  input  1  update enable: OPq instruction in execute.
- stall  input  1  pipeline hold; blocks CC update when high.
- alu_fun  input  4  0=add, 1=sub, 2=and, 3=xor; other codes are illegal.
- alu_a  input  n  ALU operand A (valA / valC side).
- alu_b  input  n  ALU operand B (valB side).
- alu_out  input  n  ALU result valE (add: b+a, sub: b-a, and: b&a, xor: b^a).
- cond_fun  input  4  ifun of jXX/cmovXX: 0 always, 1 le, 2 l, 3 e, 4 ne, 5 ge, 6 g.
- zf  output  1  stored zero flag.
- sf  output  1  stored sign flag.
- of  output  1  stored overflow flag.
- cnd  output  1  condition result, combinational from stored flags.
- cc_valid  output  1  high once at least one CC update has occurred since reset.
- cc_err  output  1  sticky illegal-alu_fun-on-update flag.

Behaviour:
- Reset: when rst_n=0, asynchronously and regardless of clk, zf=1, sf=0, of=0, cc_valid=0, cc_err=0. Release is synchronous to the next rising edge.
- Next-flag computation (combinational, internal):
  - nz = (alu_out == 0).
  - ns = alu_out[n-1].
- Next overflow no:
  - add: no = (a[n-1]==b[n-1]) & (out[n-1]!=a[n-1]).
  - sub: no = (a[n-1]!=b[n-1]) & (out[n-1]!=b[n-1]).
  - and/xor: no = 0.
- Update rule, on rising clk when set_cc=1 and stall=0:
  - alu_fun 0..3: {zf,sf,of} <= {nz,ns,no}; cc_valid <= 1.
  - alu_fun >3: flags hold; cc_err <= 1.
- When set_cc=0 or stall=1, all registers hold. stall has priority over set_cc.
- cc_err clears only on reset.
- Latency:
  - Flags become visible on zf/sf/of one cycle after the update edge.
  - cnd in the same cycle as set_cc uses the old flags, matching SEQ semantics where an OPq never tests its own result.
- cnd decoding, from stored flags:
  - 0: 1.
  - 1: (sf^of)|zf.
  - 2: sf^of.
  - 3: zf.
  - 4: ~zf.
  - 5: ~(sf^of).
  - 6: ~(sf^of)&~zf.
  - 7..15: 0.
- cnd is purely combinational from cond_fun and the CC register; it carries no registered latency.
- Asserting reset in the same cycle as an update: reset wins and flags take reset values.
- No internal FSM beyond the CC register and the cc_valid/cc_err bits. cc_valid transitions 0->1 only, and returns to 0 only on reset.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with set_cc=1 -> zf=1, sf=0, of=0, cc_valid=0 immediately; cond_fun=3 -> cnd=1.
- XOR zero: alu_fun=3, a=b=0xDEADBEEF_00000001, out=0, set_cc=1, one edge -> zf=1, sf=0, of=0, cc_valid=1; then cond_fun=4 -> cnd=0.
- Add overflow: alu_fun=0, a=b=0x7FFF_FFFF_FFFF_FFFF, out=0xFFFF_FFFF_FFFF_FFFE -> zf=0, sf=1, of=1; cond_fun=2 -> cnd=0; cond_fun=5 -> cnd=1.
- Sub overflow: alu_fun=1, a=1, b=0x8000_0000_0000_0000, out=0x7FFF_FFFF_FFFF_FFFF -> sf=0, of=1; cond_fun=1 -> cnd=1.
- Hold, stall and old-flag cnd:
  - stall=1 with set_cc=1 and out=0 -> flags unchanged.
  - Same-cycle cnd reflects the prior flags; the new flags appear only after an unstalled edge.
- Illegal op: alu_fun=7, set_cc=1 -> flags hold, cc_err=1 and stays 1 through later legal updates until rst_n=0.

Source files
------------

// File: rtl/cc_unit.sv
// Y86-64 condition-code unit: derives ZF/SF/OF from the ALU operands and result,
// holds them in the CC register and evaluates the jXX/cmovXX condition from the stored flags.
module cc_unit #(
    parameter int n = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         set_cc,
    input  logic         stall,
    input  logic [3:0]   alu_fun,
    input  logic [n-1:0] alu_a,
    input  logic [n-1:0] alu_b,
    input  logic [n-1:0] alu_out,
    input  logic [3:0]   cond_fun,
    output logic         zf,
    output logic         sf,
    output logic         of,
    output logic         cnd,
    output logic         cc_valid,
    output logic         cc_err
);

    localparam logic [3:0] FUN_ADD = 4'd0;
    localparam logic [3:0] FUN_SUB = 4'd1;
    localparam logic [3:0] FUN_AND = 4'd2;
    localparam logic [3:0] FUN_XOR = 4'd3;

    // Signed overflow of b+a: operands agree in sign, result does not.
    function automatic logic ovf_add(input logic a_msb, input logic b_msb, input logic o_msb);
        return (a_msb == b_msb) && (o_msb != a_msb);
    endfunction

    // Signed overflow of b-a: operands differ in sign, result sign differs from b.
    function automatic logic ovf_sub(input logic a_msb, input logic b_msb, input logic o_msb);
        return (a_msb != b_msb) && (o_msb != b_msb);
    endfunction

    logic zf_q, sf_q, of_q, valid_q, err_q;
    logic zf_d, sf_d, of_d, valid_d, err_d;
    logic nz_s, ns_s, lt_s, cnd_s, upd_s;
    logic unused_ok_s;

    assign nz_s  = (alu_out == {n{1'b0}});
    assign ns_s  = alu_out[n-1];
    assign upd_s = set_cc & ~stall;
    // Only the operand sign bits feed the overflow logic.
    assign unused_ok_s = ^{alu_a[n-2:0], alu_b[n-2:0]};

    // Next-state for the CC register and the sticky status bits.
    always_comb begin
        zf_d    = zf_q;
        sf_d    = sf_q;
        of_d    = of_q;
        valid_d = valid_q;
        err_d   = err_q;
        if (upd_s) begin
            case (alu_fun)
                FUN_ADD: begin
                    zf_d    = nz_s;
                    sf_d    = ns_s;
                    of_d    = ovf_add(alu_a[n-1], alu_b[n-1], alu_out[n-1]);
                    valid_d = 1'b1;
                end
                FUN_SUB: begin
                    zf_d    = nz_s;
                    sf_d    = ns_s;
                    of_d    = ovf_sub(alu_a[n-1], alu_b[n-1], alu_out[n-1]);
                    valid_d = 1'b1;
                end
                FUN_AND, FUN_XOR: begin
                    zf_d    = nz_s;
                    sf_d    = ns_s;
                    of_d    = 1'b0;
                    valid_d = 1'b1;
                end
                default: begin
                    err_d = 1'b1;
                end
            endcase
        end else begin
            err_d = err_q;
        end
    end

    // CC register; reset leaves the machine as if the last result was zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zf_q    <= 1'b1;
            sf_q    <= 1'b0;
            of_q    <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            zf_q    <= zf_d;
            sf_q    <= sf_d;
            of_q    <= of_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign lt_s = sf_q ^ of_q;

    // Condition decode works only on stored flags, so an OPq never sees its own result.
    always_comb begin
        cnd_s = 1'b0;
        case (cond_fun)
            4'd0:    cnd_s = 1'b1;
            4'd1:    cnd_s = lt_s | zf_q;
            4'd2:    cnd_s = lt_s;
            4'd3:    cnd_s = zf_q;
            4'd4:    cnd_s = ~zf_q;
            4'd5:    cnd_s = ~lt_s;
            4'd6:    cnd_s = ~lt_s & ~zf_q;
            default: cnd_s = 1'b0;
        endcase
    end

    assign zf       = zf_q;
    assign sf       = sf_q;
    assign of       = of_q;
    assign cc_valid = valid_q;
    assign cc_err   = err_q;
    assign cnd      = cnd_s;

endmodule
